// File: rtl/uart_pkg.sv
// Shared UART definitions: frame geometry and LED mode encoding.
// Imported by the tx indicator and its interface.
package uart_pkg;

  localparam int FRAME_BITS  = 10;
  localparam int LAST_BIT_ID = 9;
  localparam int BIT_ID_W    = 4;

  typedef enum logic [1:0] {
    LED_IDLE,
    LED_ACTIVE,
    LED_FAULT
  } led_mode_e;

  // Counter width that never collapses to zero bits.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_tx_indicator_if.sv
// Tx-side signals seen by the status LED driver.
// master = transmitter/bench side, slave = indicator.
interface uart_tx_indicator_if;
  import uart_pkg::*;

  logic                tx_clk;
  logic [BIT_ID_W-1:0] bit_ID;
  logic                green_LED;
  logic                red_LED;

  modport master (
    output tx_clk,
    output bit_ID,
    input  green_LED,
    input  red_LED
  );

  modport slave (
    input  tx_clk,
    input  bit_ID,
    output green_LED,
    output red_LED
  );

endinterface

// File: rtl/sync_edge_det.sv
// Two-flop synchroniser followed by a registered rising-edge pulse.
// Pulse appears 3 clk edges after the async rise, lasting 1 cycle.
module sync_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic rise
);

  logic s1;
  logic s2;
  logic s3;

  // Synchronise, delay once more, and register the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1   <= 1'b0;
      s2   <= 1'b0;
      s3   <= 1'b0;
      rise <= 1'b0;
    end else begin
      s1   <= async_in;
      s2   <= s1;
      s3   <= s2;
      rise <= s2 & ~s3;
    end
  end

endmodule

// File: rtl/uart_tx_indicator.sv
// Status LEDs for the UART transmitter: green idle, red busy,
// both blinking together once an illegal bit index is seen.
module uart_tx_indicator
  import uart_pkg::*;
#(
  parameter int HOLD_CYCLES  = 50_000_000,
  parameter int BLINK_CYCLES = 12_500_000,
  parameter int LAST_BIT_ID  = uart_pkg::LAST_BIT_ID
) (
  input logic                 int_clk,
  input logic                 rst,
  uart_tx_indicator_if.slave  tx
);

  localparam int HW = $clog2(HOLD_CYCLES + 1);
  localparam int BW = cnt_w(BLINK_CYCLES);

  localparam logic [HW-1:0] HOLD_LD    = HW'(HOLD_CYCLES);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_CYCLES - 1);
  localparam logic [BIT_ID_W-1:0] LAST_ID = BIT_ID_W'(LAST_BIT_ID);

  logic                tx_rise;
  logic [HW-1:0]       hold_cnt;
  logic [BIT_ID_W-1:0] bit_q;
  logic                fault;
  logic                blink_ph;
  logic [BW-1:0]       blink_cnt;
  logic                active;
  logic                bad_id;
  led_mode_e           mode;

  sync_edge_det u_sync (
    .clk      (int_clk),
    .rst      (rst),
    .async_in (tx.tx_clk),
    .rise     (tx_rise)
  );

  assign bad_id = tx.bit_ID > LAST_ID;
  assign active = (hold_cnt != '0) | (bit_q != '0);

  // Capture the bit index on each tx edge and keep red lit a while after.
  always_ff @(posedge int_clk) begin
    if (rst) begin
      hold_cnt <= '0;
      bit_q    <= '0;
    end else if (tx_rise) begin
      hold_cnt <= HOLD_LD;
      bit_q    <= tx.bit_ID;
    end else if (hold_cnt != '0) begin
      hold_cnt <= hold_cnt - HW'(1);
    end
  end

  // Sticky fault with a free-running blink phase once latched.
  always_ff @(posedge int_clk) begin
    if (rst) begin
      fault     <= 1'b0;
      blink_ph  <= 1'b0;
      blink_cnt <= '0;
    end else if (!fault) begin
      if (tx_rise && bad_id) begin
        fault     <= 1'b1;
        blink_ph  <= 1'b1;
        blink_cnt <= '0;
      end
    end else if (blink_cnt == BLINK_LAST) begin
      blink_cnt <= '0;
      blink_ph  <= ~blink_ph;
    end else begin
      blink_cnt <= blink_cnt + BW'(1);
    end
  end

  // Fault outranks activity, activity outranks idle.
  always_comb begin
    mode = LED_IDLE;
    if (fault) begin
      mode = LED_FAULT;
    end else if (active) begin
      mode = LED_ACTIVE;
    end
  end

  // Register the LEDs from the selected mode.
  always_ff @(posedge int_clk) begin
    if (rst) begin
      tx.green_LED <= 1'b1;
      tx.red_LED   <= 1'b0;
    end else begin
      unique case (mode)
        LED_FAULT: begin
          tx.green_LED <= blink_ph;
          tx.red_LED   <= blink_ph;
        end
        LED_ACTIVE: begin
          tx.green_LED <= 1'b0;
          tx.red_LED   <= 1'b1;
        end
        default: begin
          tx.green_LED <= 1'b1;
          tx.red_LED   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_indicator.sv
// Directed bench for the tx status LED driver.
// HOLD_CYCLES=8, BLINK_CYCLES=4.
module tb_uart_tx_indicator;
  import uart_pkg::*;

  logic int_clk = 1'b0;
  logic rst     = 1'b1;
  int   checks  = 0;
  int   errors  = 0;

  uart_tx_indicator_if tx_if ();

  uart_tx_indicator #(
    .HOLD_CYCLES  (8),
    .BLINK_CYCLES (4)
  ) dut (
    .int_clk (int_clk),
    .rst     (rst),
    .tx      (tx_if)
  );

  always #5 int_clk = ~int_clk;

  task automatic tick(input int n);
    repeat (n) @(posedge int_clk);
    #1;
  endtask

  function automatic logic [1:0] leds();
    return {tx_if.green_LED, tx_if.red_LED};
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    tick(2);
    checks++;
    if (leds() !== 2'b10) begin
      errors++;
      $display("FAIL reset_hold: got gr=%b want 10", leds());
    end
    rst = 1'b0;
    tick(1);
    checks++;
    if (leds() !== 2'b10) begin
      errors++;
      $display("FAIL reset_release: got gr=%b want 10", leds());
    end
    tick(20);
    checks++;
    if (leds() !== 2'b10) begin
      errors++;
      $display("FAIL reset_stable: got gr=%b want 10", leds());
    end
  endtask

  task automatic test_single_edge();
    tx_if.bit_ID = 4'd1;
    tx_if.tx_clk = 1'b1;
    tick(4);
    checks++;
    if (leds() !== 2'b10) begin
      errors++;
      $display("FAIL single_early: got gr=%b want 10", leds());
    end
    tick(1);
    checks++;
    if (leds() !== 2'b01) begin
      errors++;
      $display("FAIL single_lit: got gr=%b want 01", leds());
    end
    tx_if.tx_clk = 1'b0;
    tick(30);
    checks++;
    if (leds() !== 2'b01) begin
      errors++;
      $display("FAIL single_stopped: got gr=%b want 01", leds());
    end
  endtask

  task automatic test_full_frame();
    int drops = 0;
    for (int i = 1; i <= 9; i++) begin
      tx_if.bit_ID = 4'(i);
      tx_if.tx_clk = 1'b1;
      for (int j = 0; j < 20; j++) begin
        if (j == 10) tx_if.tx_clk = 1'b0;
        tick(1);
        if (leds() !== 2'b01) drops++;
      end
    end
    checks++;
    if (drops !== 0) begin
      errors++;
      $display("FAIL frame_continuous: got %0d drops want 0", drops);
    end
    tx_if.bit_ID = 4'd0;
    tx_if.tx_clk = 1'b1;
    tick(10);
    tx_if.tx_clk = 1'b0;
    tick(2);
    checks++;
    if (leds() !== 2'b01) begin
      errors++;
      $display("FAIL frame_hold_tail: got gr=%b want 01", leds());
    end
    tick(1);
    checks++;
    if (leds() !== 2'b10) begin
      errors++;
      $display("FAIL frame_idle: got gr=%b want 10", leds());
    end
  endtask

  task automatic test_spaced_rises(input string nm, input int gap,
                                   input int n);
    int drops = 0;
    tx_if.bit_ID = 4'd0;
    for (int k = 0; k < n; k++) begin
      tx_if.tx_clk = 1'b1;
      for (int j = 0; j < gap; j++) begin
        if (j == gap / 2) tx_if.tx_clk = 1'b0;
        tick(1);
        if ((k > 0 || j >= 4) && leds() !== 2'b01) drops++;
      end
    end
    checks++;
    if (drops !== 0) begin
      errors++;
      $display("FAIL %s_continuous: got %0d drops want 0", nm, drops);
    end
    tick(12 - gap);
    checks++;
    if (leds() !== 2'b01) begin
      errors++;
      $display("FAIL %s_tail: got gr=%b want 01", nm, leds());
    end
    tick(1);
    checks++;
    if (leds() !== 2'b10) begin
      errors++;
      $display("FAIL %s_idle: got gr=%b want 10", nm, leds());
    end
  endtask

  task automatic test_back_to_back();
    test_spaced_rises("retrigger", 6, 5);
  endtask

  task automatic test_reload_boundary();
    test_spaced_rises("reload", 8, 3);
  endtask

  task automatic test_fault();
    int ones = 0;
    int split = 0;
    tx_if.bit_ID = 4'd12;
    tx_if.tx_clk = 1'b1;
    tick(4);
    tx_if.tx_clk = 1'b0;
    tick(1);
    checks++;
    if (leds() !== 2'b11) begin
      errors++;
      $display("FAIL fault_first_high: got gr=%b want 11", leds());
    end
    tick(3);
    checks++;
    if (leds() !== 2'b11) begin
      errors++;
      $display("FAIL fault_high_end: got gr=%b want 11", leds());
    end
    tick(1);
    checks++;
    if (leds() !== 2'b00) begin
      errors++;
      $display("FAIL fault_low_start: got gr=%b want 00", leds());
    end
    tick(3);
    checks++;
    if (leds() !== 2'b00) begin
      errors++;
      $display("FAIL fault_low_end: got gr=%b want 00", leds());
    end
    tick(1);
    checks++;
    if (leds() !== 2'b11) begin
      errors++;
      $display("FAIL fault_high_again: got gr=%b want 11", leds());
    end
    tx_if.bit_ID = 4'd1;
    tx_if.tx_clk = 1'b1;
    tick(4);
    tx_if.tx_clk = 1'b0;
    tx_if.bit_ID = 4'd0;
    for (int j = 0; j < 16; j++) begin
      tick(1);
      if (tx_if.green_LED !== tx_if.red_LED) split++;
      if (tx_if.red_LED === 1'b1) ones++;
    end
    checks++;
    if (split !== 0 || ones !== 8) begin
      errors++;
      $display("FAIL fault_sticky: got split=%0d ones=%0d want 0/8",
               split, ones);
    end
    tick(4);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    checks++;
    if (leds() !== 2'b10) begin
      errors++;
      $display("FAIL fault_rst: got gr=%b want 10", leds());
    end
    tick(10);
    checks++;
    if (leds() !== 2'b10) begin
      errors++;
      $display("FAIL fault_cleared: got gr=%b want 10", leds());
    end
  endtask

  task automatic test_reset_midframe();
    tx_if.bit_ID = 4'd3;
    tx_if.tx_clk = 1'b1;
    tick(4);
    tx_if.tx_clk = 1'b0;
    tick(2);
    checks++;
    if (leds() !== 2'b01) begin
      errors++;
      $display("FAIL mid_lit: got gr=%b want 01", leds());
    end
    rst = 1'b1;
    tick(1);
    checks++;
    if (leds() !== 2'b10) begin
      errors++;
      $display("FAIL mid_rst: got gr=%b want 10", leds());
    end
    rst = 1'b0;
    tick(5);
    checks++;
    if (leds() !== 2'b10) begin
      errors++;
      $display("FAIL mid_after: got gr=%b want 10", leds());
    end
  endtask

  initial begin
    tx_if.tx_clk = 1'b0;
    tx_if.bit_ID = 4'd0;
    test_reset();
    test_single_edge();
    test_full_frame();
    test_back_to_back();
    test_reload_boundary();
    test_fault();
    test_reset_midframe();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
